// File: rtl/fb_pkg.sv
// Shared types and constants for the multi-buffered frame store.
package fb_pkg;

  // Page index; wide enough for up to three pages.
  typedef logic [1:0] page_t;

  // Buffer-swap state. PENDING doubles as the "completed page waiting for
  // vblank" valid flag in the three-page configuration.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } fb_state_t;

  localparam page_t RST_WR_PAGE   = 2'd0;
  localparam page_t RST_RD_PAGE   = 2'd1;
  localparam page_t RST_FREE_PAGE = 2'd2;

  // RAM address width: pixel bits plus enough bits to select a page.
  function automatic int fb_ram_aw(input int h_bits, input int v_bits, input int nbuf);
    return h_bits + v_bits + $clog2(nbuf);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module fb_ram #(
  parameter int AW    = 17,
  parameter int DEPTH = 131072,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic          i_re,
  input  logic [AW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [DW-1:0] r_rd;

  // Write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end

  // Registered read; a same-address write in this cycle is not visible yet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rd <= '0;
    else if (i_re) r_rd <= r_mem[i_ra];
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/fb_multibuf.sv
// Double/triple-buffered frame store: producer writes one page while the
// display reads another; completed pages are swapped in at vertical blank.
module fb_multibuf
  import fb_pkg::*;
#(
  parameter int H_BITS = 8,
  parameter int V_BITS = 8,
  parameter int PIX_W  = 8,
  parameter int NBUF   = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [H_BITS-1:0] wr_x,
  input  logic [V_BITS-1:0] wr_y,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic              frame,
  input  logic              rd_ce,
  input  logic [H_BITS-1:0] rd_x,
  input  logic [V_BITS-1:0] rd_y,
  input  logic              rd_vb,
  output logic [PIX_W-1:0]  rd_pix,
  output logic              rd_valid,
  output logic [1:0]        wr_page,
  output logic [1:0]        rd_page,
  output logic              flip,
  output logic [7:0]        drop_cnt
);

  localparam int RAM_AW = fb_ram_aw(H_BITS, V_BITS, NBUF);
  localparam int PG_W   = RAM_AW - H_BITS - V_BITS;
  localparam int DEPTH  = NBUF << (H_BITS + V_BITS);

  logic      r_frame_d, r_vb_d;
  fb_state_t r_state;
  page_t     r_wr_page, r_rd_page, r_free_page, r_pend_page;
  logic      r_flip, r_rd_valid;
  logic [7:0] r_drop;

  logic      w_frame_edge, w_vb_edge;
  fb_state_t w_state_next;
  page_t     w_wr_next, w_rd_next, w_free_next, w_pend_next;
  logic      w_flip_next, w_drop_inc;
  logic      w_we;
  logic [RAM_AW-1:0] w_wa, w_ra;

  assign w_frame_edge = frame & ~r_frame_d;
  assign w_vb_edge    = rd_vb & ~r_vb_d;

  // Page bookkeeping: the frame edge is resolved first so that a vblank in
  // the same cycle can display the page that has just been completed.
  always_comb begin
    w_state_next = r_state;
    w_wr_next    = r_wr_page;
    w_rd_next    = r_rd_page;
    w_free_next  = r_free_page;
    w_pend_next  = r_pend_page;
    w_flip_next  = 1'b0;
    w_drop_inc   = 1'b0;
    if (w_frame_edge) begin
      if (r_state == ST_PENDING) begin
        // A frame is already waiting: it is lost.
        w_drop_inc = 1'b1;
        if (NBUF == 3) begin
          // Newest frame becomes pending; the stale one is overwritten next.
          w_pend_next = r_wr_page;
          w_wr_next   = r_pend_page;
        end
      end else begin
        w_state_next = ST_PENDING;
        if (NBUF == 3) begin
          w_pend_next = r_wr_page;
          w_wr_next   = r_free_page;
        end
      end
    end
    if (w_vb_edge && (w_state_next == ST_PENDING)) begin
      w_state_next = ST_IDLE;
      w_flip_next  = 1'b1;
      if (NBUF == 3) begin
        w_rd_next   = w_pend_next;
        w_free_next = r_rd_page;
      end else begin
        w_rd_next = w_wr_next;
        w_wr_next = r_rd_page;
      end
    end
  end

  // State, page, counter and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_d   <= 1'b0;
      r_vb_d      <= 1'b0;
      r_state     <= ST_IDLE;
      r_wr_page   <= RST_WR_PAGE;
      r_rd_page   <= RST_RD_PAGE;
      r_free_page <= RST_FREE_PAGE;
      r_pend_page <= RST_WR_PAGE;
      r_flip      <= 1'b0;
      r_drop      <= 8'd0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_frame_d   <= frame;
      r_vb_d      <= rd_vb;
      r_state     <= w_state_next;
      r_wr_page   <= w_wr_next;
      r_rd_page   <= w_rd_next;
      r_free_page <= w_free_next;
      r_pend_page <= w_pend_next;
      r_flip      <= w_flip_next;
      if (w_drop_inc && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      r_rd_valid  <= rd_ce;
    end
  end

  // With two pages the only write page is also the pending one, so it is
  // frozen until the display takes it.
  assign w_we = wr_en & ~((NBUF == 2) && (r_state == ST_PENDING));
  assign w_wa = {r_wr_page[PG_W-1:0], wr_y, wr_x};
  assign w_ra = {r_rd_page[PG_W-1:0], rd_y, rd_x};

  fb_ram #(
    .AW    (RAM_AW),
    .DEPTH (DEPTH),
    .DW    (PIX_W)
  ) u_ram (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_we    (w_we),
    .i_wa    (w_wa),
    .i_wd    (wr_pix),
    .i_re    (rd_ce),
    .i_ra    (w_ra),
    .o_rd    (rd_pix)
  );

  assign rd_valid = r_rd_valid;
  assign wr_page  = r_wr_page;
  assign rd_page  = r_rd_page;
  assign flip     = r_flip;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_fb_multibuf.sv
// Bench for fb_multibuf: a two-page and a three-page instance share the same
// stimulus; each is compared every cycle against a page-level reference model.
module tb_fb_multibuf;

  localparam int HB = 3;
  localparam int VB = 3;
  localparam int PAGE = 1 << (HB + VB);

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0, frame = 1'b0, rd_ce = 1'b0, rd_vb = 1'b0;
  logic [HB-1:0] wr_x = '0, rd_x = '0;
  logic [VB-1:0] wr_y = '0, rd_y = '0;
  logic [7:0] wr_pix = '0;

  logic [7:0] d2_pix, d3_pix, d2_drop, d3_drop;
  logic       d2_vld, d3_vld, d2_flip, d3_flip;
  logic [1:0] d2_wp, d3_wp, d2_rp, d3_rp;

  always #5 clk_sys = ~clk_sys;

  fb_multibuf #(.H_BITS(HB), .V_BITS(VB), .PIX_W(8), .NBUF(2)) u_dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_pix(wr_pix), .frame(frame), .rd_ce(rd_ce), .rd_x(rd_x), .rd_y(rd_y),
    .rd_vb(rd_vb), .rd_pix(d2_pix), .rd_valid(d2_vld), .wr_page(d2_wp),
    .rd_page(d2_rp), .flip(d2_flip), .drop_cnt(d2_drop));

  fb_multibuf #(.H_BITS(HB), .V_BITS(VB), .PIX_W(8), .NBUF(3)) u_dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_pix(wr_pix), .frame(frame), .rd_ce(rd_ce), .rd_x(rd_x), .rd_y(rd_y),
    .rd_vb(rd_vb), .rd_pix(d3_pix), .rd_valid(d3_vld), .wr_page(d3_wp),
    .rd_page(d3_rp), .flip(d3_flip), .drop_cnt(d3_drop));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, index 0 = two pages, index 1 = three pages.
  int  m_wr[2], m_rd[2], m_free[2], m_ready[2], m_drop[2], m_pix[2];
  bit  m_pend[2], m_flip[2], m_vld[2], m_pixk[2];
  int  mem[2][3*PAGE];
  bit  memk[2][3*PAGE];
  bit  m_pf, m_pv;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_rd[k] = 1; m_free[k] = 2; m_ready[k] = 0;
      m_pend[k] = 0; m_drop[k] = 0; m_flip[k] = 0; m_vld[k] = 0;
      m_pix[k] = 0; m_pixk[k] = 1;
    end
    m_pf = 0; m_pv = 0;
  endtask

  task automatic model_step();
    bit fe, ve;
    int tmp;
    fe = frame && !m_pf;
    ve = rd_vb && !m_pv;
    m_pf = frame;
    m_pv = rd_vb;
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = rd_ce;
      if (rd_ce) begin
        tmp = m_rd[k] * PAGE + int'(rd_y) * (1 << HB) + int'(rd_x);
        m_pix[k] = mem[k][tmp];
        m_pixk[k] = memk[k][tmp];
      end
      if (wr_en && !(k == 0 && m_pend[k])) begin
        tmp = m_wr[k] * PAGE + int'(wr_y) * (1 << HB) + int'(wr_x);
        mem[k][tmp] = int'(wr_pix);
        memk[k][tmp] = 1;
      end
      m_flip[k] = 0;
      if (fe) begin
        if (m_pend[k]) begin
          if (m_drop[k] < 255) m_drop[k]++;
          if (k == 1) begin tmp = m_ready[k]; m_ready[k] = m_wr[k]; m_wr[k] = tmp; end
        end else begin
          m_pend[k] = 1;
          if (k == 1) begin m_ready[k] = m_wr[k]; m_wr[k] = m_free[k]; end
        end
      end
      if (ve && m_pend[k]) begin
        if (k == 0) begin tmp = m_wr[k]; m_wr[k] = m_rd[k]; m_rd[k] = tmp; end
        else begin m_free[k] = m_rd[k]; m_rd[k] = m_ready[k]; end
        m_pend[k] = 0;
        m_flip[k] = 1;
      end
    end
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    logic [7:0] o_pix[2], o_drop[2];
    logic       o_vld[2], o_flip[2];
    logic [1:0] o_wp[2], o_rp[2];
    if (!reset_n) model_reset(); else model_step();
    @(posedge clk_sys);
    #1;
    o_pix[0] = d2_pix; o_drop[0] = d2_drop; o_vld[0] = d2_vld; o_flip[0] = d2_flip;
    o_wp[0] = d2_wp; o_rp[0] = d2_rp;
    o_pix[1] = d3_pix; o_drop[1] = d3_drop; o_vld[1] = d3_vld; o_flip[1] = d3_flip;
    o_wp[1] = d3_wp; o_rp[1] = d3_rp;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("n%0d_flip", k + 2), 32'(o_flip[k]), 32'(m_flip[k]));
      check($sformatf("n%0d_wr_page", k + 2), 32'(o_wp[k]), 32'(m_wr[k]));
      check($sformatf("n%0d_rd_page", k + 2), 32'(o_rp[k]), 32'(m_rd[k]));
      check($sformatf("n%0d_drop", k + 2), 32'(o_drop[k]), 32'(m_drop[k]));
      check($sformatf("n%0d_rd_valid", k + 2), 32'(o_vld[k]), 32'(m_vld[k]));
      if (m_vld[k] && m_pixk[k])
        check($sformatf("n%0d_rd_pix", k + 2), 32'(o_pix[k]), 32'(m_pix[k]));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; frame = 1'b0; rd_vb = 1'b0; wr_en = 1'b0; rd_ce = 1'b0;
    tick();
    check("rst_n2_wr_page", 32'(d2_wp), 32'd0);
    check("rst_n2_rd_page", 32'(d2_rp), 32'd1);
    check("rst_n3_wr_page", 32'(d3_wp), 32'd0);
    check("rst_n3_rd_page", 32'(d3_rp), 32'd1);
    check("rst_pix", 32'({d2_pix, d3_pix}), 32'd0);
    check("rst_flags", 32'({d2_flip, d3_flip, d2_vld, d3_vld}), 32'd0);
    check("rst_drop", 32'({d2_drop, d3_drop}), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic wr(input int x, input int y, input int pix);
    wr_en = 1'b1; wr_x = HB'(x); wr_y = VB'(y); wr_pix = 8'(pix);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int x, input int y);
    rd_ce = 1'b1; rd_x = HB'(x); rd_y = VB'(y);
    tick();
    rd_ce = 1'b0;
  endtask

  task automatic frame_pulse();
    frame = 1'b1; tick(); frame = 1'b0; tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 3 * PAGE; a++) begin mem[k][a] = 0; memk[k][a] = 0; end
    model_reset();
    do_reset();

    // First frame displayed after vblank.
    wr(3, 2, 'hA5);
    frame = 1'b1; tick();
    rd_vb = 1'b1; tick();
    check("s1_flip", 32'({d2_flip, d3_flip}), 32'b11);
    check("s1_rd_page", 32'(d2_rp), 32'd0);
    frame = 1'b0; rd_vb = 1'b0; tick();
    check("s1_no_second_flip", 32'({d2_flip, d3_flip}), 32'b00);
    rd(3, 2);
    check("s1_rd_pix", 32'(d2_pix), 32'hA5);

    // Two-page writes are frozen while pending; second frame is dropped.
    do_reset();
    wr(0, 0, 'h5A);
    frame_pulse();
    wr(0, 0, 'h11);
    frame_pulse();
    check("s2_drop", 32'(d2_drop), 32'd1);
    rd_vb = 1'b1; tick(); rd_vb = 1'b0; tick();
    rd(0, 0);
    check("s2_page0_kept", 32'(d2_pix), 32'h5A);

    // Three frames without vblank; newest frame wins.
    do_reset();
    wr(1, 1, 'h31); frame_pulse();
    wr(1, 1, 'h32); frame_pulse();
    wr(1, 1, 'h33); frame_pulse();
    check("s3_drop", 32'(d3_drop), 32'd2);
    rd_vb = 1'b1; tick();
    check("s3_flip", 32'(d3_flip), 32'd1);
    rd_vb = 1'b0; tick();
    rd(1, 1);
    check("s3_rd_pix", 32'(d3_pix), 32'h33);

    // Frame and vblank edges in the same cycle.
    do_reset();
    wr(2, 2, 'h44);
    frame = 1'b1; rd_vb = 1'b1; tick();
    check("s4_flip", 32'({d2_flip, d3_flip}), 32'b11);
    check("s4_rd_page", 32'({d2_rp, d3_rp}), 32'h0);
    frame = 1'b0; rd_vb = 1'b0; tick();
    rd(2, 2);
    check("s4_rd_pix", 32'({d2_pix, d3_pix}), 32'h4444);

    // Reset while pending discards the flip.
    do_reset();
    frame = 1'b1; tick();
    do_reset();
    rd_vb = 1'b1; tick();
    check("s5_no_flip", 32'({d2_flip, d3_flip}), 32'b00);
    rd_vb = 1'b0; tick();

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) frame_pulse();
    check("s6_drop_sat", 32'({d2_drop, d3_drop}), 32'hFFFF);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      wr_en = 1'($urandom_range(1)); wr_x = HB'($urandom_range(7));
      wr_y = VB'($urandom_range(7)); wr_pix = 8'($urandom_range(255));
      rd_ce = 1'($urandom_range(1)); rd_x = HB'($urandom_range(7));
      rd_y = VB'($urandom_range(7));
      if ($urandom_range(5) == 0) frame = ~frame;
      if ($urandom_range(7) == 0) rd_vb = ~rd_vb;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_multibuf.md
FB_MULTIBUF -- requirements
Module: fb_multibuf

Interface
REQ-001 SHALL have parameter H_BITS, default 8, meaning horizontal address bits; a line holds 2^H_BITS pixels.
REQ-002 SHALL have parameter V_BITS, default 8, meaning vertical address bits; a page holds 2^V_BITS lines.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel word width.
REQ-004 SHALL have parameter NBUF, default 2, meaning page count; legal values are 2 and 3.
REQ-005 SHALL have port clk_sys, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, 1, pixel write strobe.
REQ-008 SHALL have ports wr_x / wr_y, input, H_BITS / V_BITS, write coordinates.
REQ-009 SHALL have port wr_pix, input, PIX_W, write data.
REQ-010 SHALL have port frame, input, 1, level signal from the producer; its rising edge marks the write page complete.
REQ-011 SHALL have port rd_ce, input, 1, pixel read enable from the video timing.
REQ-012 SHALL have ports rd_x / rd_y, input, H_BITS / V_BITS, read coordinates.
REQ-013 SHALL have port rd_vb, input, 1, vertical blank level.
REQ-014 SHALL have port rd_pix, output, PIX_W, registered read data.
REQ-015 SHALL have port rd_valid, output, 1, qualifies rd_pix.
REQ-016 SHALL have ports wr_page / rd_page, output, 2, current write / display page index.
REQ-017 SHALL have port flip, output, 1, one-cycle pulse when the display page changes.
REQ-018 SHALL have port drop_cnt, output, 8, saturating count of lost frames.

Function
REQ-019 SHALL detect rising edges of frame and rd_vb with one register each; the edge is acted on in the cycle after the input rises.
REQ-020 SHALL write wr_pix to word wr_page*2^(H_BITS+V_BITS) + wr_y*2^H_BITS + wr_x when wr_en=1 and the write is not blocked.
REQ-021 SHALL register rd_pix from page rd_page at (rd_y, rd_x) one cycle after rd_ce=1, with rd_valid=1 for exactly that cycle.
REQ-022 SHALL, for NBUF=2, use states IDLE and PENDING: a frame edge moves IDLE to PENDING; an rd_vb edge in PENDING swaps wr_page and rd_page, pulses flip, and returns to IDLE.
REQ-023 SHALL, for NBUF=2 in PENDING, block writes; a frame edge there increments drop_cnt and leaves the state unchanged.
REQ-024 SHALL, for NBUF=3, track a free page F and a pending page P with a valid flag.
REQ-025 SHALL, for NBUF=3 on a frame edge with no P, set P=wr_page and wr_page=F, and mark P valid.
REQ-026 SHALL, for NBUF=3 on a frame edge with P valid, exchange P and wr_page (the newest frame replaces the stale one) and increment drop_cnt.
REQ-027 SHALL, for NBUF=3 on an rd_vb edge with P valid, set rd_page=P and F=old rd_page, clear the valid flag, and pulse flip.
REQ-028 SHALL never block writes when NBUF=3.
REQ-029 SHALL, when frame and rd_vb edges act in the same cycle, apply the frame edge first; the flip uses the page just completed.
REQ-030 SHALL take no action on an rd_vb edge while nothing is pending; flip stays 0.
REQ-031 SHALL hold drop_cnt at 255 once it is reached.
REQ-032 SHALL return the old data on a same-cycle read and write to one address; a read-during-write is not required to see the new data.

Reset
REQ-033 SHALL, while reset_n=0, force wr_page=0, rd_page=1, F=2, pending flag 0, state IDLE, rd_pix=0, rd_valid=0, flip=0, drop_cnt=0 and both edge registers 0.
REQ-034 SHALL discard any pending flip on reset mid-frame and SHALL NOT clear RAM contents.

Structure
REQ-035 SHALL place the page-index type, state enumeration and derived address-width constant in shared package fb_pkg.
REQ-036 SHALL instantiate one sub-module fb_ram: a simple dual-port RAM with 1-cycle registered read, depth NBUF*2^(H_BITS+V_BITS), width PIX_W.

Verification
REQ-037 SHALL cover this scenario: NBUF=2; write 0xA5 to (3,2); raise frame; then raise rd_vb -> flip pulses once, rd_page=0, and reading (3,2) gives rd_pix=0xA5 one cycle after rd_ce.
REQ-038 SHALL cover this scenario: NBUF=2, PENDING; write 0x11 to (0,0); raise frame again -> RAM page 0 is unchanged and drop_cnt=1.
REQ-039 SHALL cover this scenario: NBUF=3; complete three frames with no vblank -> drop_cnt=2, and the next vblank displays the third frame.
REQ-040 SHALL cover this scenario: frame and rd_vb rise in the same cycle from IDLE -> flip occurs in that cycle and rd_page shows the just-completed page.
REQ-041 SHALL cover this scenario: assert reset_n=0 in PENDING, then release it -> wr_page=0, rd_page=1, and an rd_vb edge produces no flip.
REQ-042 SHALL cover this scenario: 300 dropped frames -> drop_cnt=255.
